pc_fetch_unit: RTL and testbench

- Consumer of the branch-taken select. Holds the program counter, fetches instructions from instruction memory over a req/gnt/rvalid handshake, and presents them to decode with a valid/ready handshake.
- On each instruction retirement it advances the PC to PC+4 or to the branch target, as chosen by pc_sel.
- Sits between instruction memory and decode/execute, replacing the bare PC register plus next-PC mux.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/next_pc_calc.sv | 28 ++
 rtl/pc_fetch_unit.sv | 135 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: FSM state encoding, PC increment and default reset PC.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam int          PC_INC           = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential PC+4 or PC+4+(sext(offset)<<2).
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int OFFS_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_sel,
    input  logic [OFFS_W-1:0] branch_offset,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misaligned
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] offs_ext;
    logic [ADDR_W-1:0] target;

    assign seq_pc   = pc + ADDR_W'(PC_INC);
    assign offs_ext = ADDR_W'($signed(branch_offset));
    assign target   = seq_pc + (offs_ext << 2);

    // Branch targets are word-aligned by dropping the low bits; the raw bits
    // still drive the misalign flag so the top can choose to trap instead.
    assign misaligned = pc_sel && (target[1:0] != 2'b00);
    assign next_pc    = pc_sel ? {target[ADDR_W-1:2], 2'b00} : seq_pc;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus single-outstanding instruction fetch FSM (IDLE/REQ/WAIT/HOLD).
// Define PC_ALIGN_CHECK_EN to add the sticky misalign output and halt on misaligned branches.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          OFFS_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              pc_sel,
    input  logic [OFFS_W-1:0] branch_offset,
    output logic [ADDR_W-1:0] pc_out,
    output logic [1:0]        state_dbg
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    // Handshakes: imem request completes on the cycle imem_req && imem_gnt are
    // both high; decode consumes on the cycle instr_valid && instr_ready are both
    // high. imem_addr and instr/instr_pc are held stable until their handshake.

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] next_pc;
    logic              target_misaligned;
    logic              align_fault;

    next_pc_calc #(
        .ADDR_W (ADDR_W),
        .OFFS_W (OFFS_W)
    ) u_next_pc (
        .pc            (pc_q),
        .pc_sel        (pc_sel),
        .branch_offset (branch_offset),
        .next_pc       (next_pc),
        .misaligned    (target_misaligned)
    );

    assign align_fault = ALIGN_CHECK && target_misaligned;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        imem_req   = 1'b0;
        case (state_q)
            IDLE: begin
                // A latched misalign parks the unit here until reset.
                if (en && !misalign_q) state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    if (align_fault) begin
                        misalign_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        pc_d    = next_pc;
                        state_d = en ? REQ : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign state_dbg   = state_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, fetch, branch, stall, en-low, mid-reset, wrap.
module tb_pc_fetch_unit;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_sel;
    logic [15:0] branch_offset;
    logic [31:0] pc_out;
    logic [1:0]  state_dbg;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    pc_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc_sel        (pc_sel),
        .branch_offset (branch_offset),
        .pc_out        (pc_out),
        .state_dbg     (state_dbg)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign      (misalign)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From REQ: grant after one cycle, return data the next cycle; ends in HOLD.
    task automatic fetch_to_hold(input logic [31:0] data);
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    task automatic consume(input logic sel, input logic [15:0] off);
        instr_ready   = 1'b1;
        pc_sel        = sel;
        branch_offset = off;
        step();
        instr_ready   = 1'b0;
        pc_sel        = 1'b0;
        branch_offset = 16'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b0; pc_sel = 1'b0; branch_offset = 16'h0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", state_dbg, S_IDLE); end
        n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc_out); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc got %h exp 0", instr_pc); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
`ifdef PC_ALIGN_CHECK_EN
        n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b exp 0", misalign); end
`endif
    endtask

    task automatic test_basic_fetch();
        en = 1'b1;
        step();
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr got %h exp 0", imem_addr); end
        fetch_to_hold(32'h2002_0005);
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", instr_valid); end
        n_cmp++; if (instr !== 32'h2002_0005) begin n_fail++; $display("FAIL basic_instr got %h exp 20020005", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL basic_instr_pc got %h exp 0", instr_pc); end
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_hold_req got %b exp 0", imem_req); end
        consume(1'b0, 16'h0);
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_next_req got %b exp 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next_addr got %h exp 4", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consumed_valid got %b exp 0", instr_valid); end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            fetch_to_hold(32'h1000_0000 + i);
            consume(1'b0, 16'h0);
        end
        n_cmp++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL branch_setup_addr got %h exp 10", imem_addr); end
        fetch_to_hold(32'h1111_0000);
        n_cmp++; if (instr_pc !== 32'h10) begin n_fail++; $display("FAIL branch_instr_pc got %h exp 10", instr_pc); end
        consume(1'b1, 16'hFFFE);
        n_cmp++; if (imem_addr !== 32'h0C) begin n_fail++; $display("FAIL branch_back_addr got %h exp 0c", imem_addr); end
        fetch_to_hold(32'h1111_0001);
        consume(1'b0, 16'h0);
        fetch_to_hold(32'h1111_0002);
        consume(1'b0, 16'hFFFE);
        n_cmp++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL branch_nottaken_addr got %h exp 14", imem_addr); end
        fetch_to_hold(32'h1111_0003);
        consume(1'b1, 16'h0003);
        n_cmp++; if (imem_addr !== 32'h24) begin n_fail++; $display("FAIL branch_fwd_addr got %h exp 24", imem_addr); end
    endtask

    task automatic test_hold_stall();
        fetch_to_hold(32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc %0d got %b exp 1", i, instr_valid); end
            n_cmp++; if (instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_instr cyc %0d got %h exp deadbeef", i, instr); end
            n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req cyc %0d got %b exp 0", i, imem_req); end
            step();
        end
        n_cmp++; if (state_dbg !== S_HOLD) begin n_fail++; $display("FAIL stall_state got %0d exp %0d", state_dbg, S_HOLD); end
        consume(1'b0, 16'h0);
        n_cmp++; if (imem_addr !== 32'h28) begin n_fail++; $display("FAIL stall_next_addr got %h exp 28", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stall_consumed got %b exp 0", instr_valid); end
    endtask

    task automatic test_en_low();
        en = 1'b0;
        fetch_to_hold(32'h0BAD_F00D);
        n_cmp++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL enlow_valid got %b exp 1", instr_valid); end
        n_cmp++; if (instr_pc !== 32'h28) begin n_fail++; $display("FAIL enlow_instr_pc got %h exp 28", instr_pc); end
        consume(1'b0, 16'h0);
        n_cmp++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL enlow_state got %0d exp %0d", state_dbg, S_IDLE); end
        n_cmp++; if (pc_out !== 32'h2C) begin n_fail++; $display("FAIL enlow_pc got %h exp 2c", pc_out); end
        step();
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL enlow_idle_req got %b exp 0", imem_req); end
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        step();
        n_cmp++; if (imem_addr !== 32'h2C) begin n_fail++; $display("FAIL mid_req_addr got %h exp 2c", imem_addr); end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        n_cmp++; if (state_dbg !== S_WAIT) begin n_fail++; $display("FAIL mid_wait_state got %0d exp %0d", state_dbg, S_WAIT); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL mid_async_state got %0d exp %0d", state_dbg, S_IDLE); end
        n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL mid_async_pc got %h exp 0", pc_out); end
        step();
        rst_n = 1'b1; en = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_valid got %b exp 0", instr_valid); end
        n_cmp++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL mid_stale_state got %0d exp %0d", state_dbg, S_IDLE); end
        en = 1'b1;
        step();
        step();
        n_cmp++; if (state_dbg !== S_REQ) begin n_fail++; $display("FAIL mid_req_ignores_rvalid got %0d exp %0d", state_dbg, S_REQ); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_refetch_addr got %h exp 0", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_valid got %b exp 0", instr_valid); end
        imem_rvalid = 1'b0;
        fetch_to_hold(32'h1234_5678);
        n_cmp++; if (instr !== 32'h1234_5678) begin n_fail++; $display("FAIL mid_instr got %h exp 12345678", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL mid_instr_pc got %h exp 0", instr_pc); end
        consume(1'b0, 16'h0);
    endtask

    task automatic test_wrap();
        fetch_to_hold(32'hCAFE_0001);
        consume(1'b1, 16'hFFFD);
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_branch_addr got %h exp fffffffc", imem_addr); end
        fetch_to_hold(32'hCAFE_0002);
        n_cmp++; if (instr_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_instr_pc got %h exp fffffffc", instr_pc); end
        consume(1'b0, 16'h0);
        n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL wrap_seq_pc got %h exp 0", pc_out); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req got %b exp 1", imem_req); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_branch();
        test_hold_stall();
        test_en_low();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
